// File: rtl/fifo_burst_drain.sv
// -----------------------------------------------------------------------------
// fifo_burst_drain
//
// Read-side consumer of a synchronous FIFO. Words are popped through the
// FIFO's rd_en/empty/dout interface (dout is registered and is valid the cycle
// after an accepted read). They are staged in a 3-entry skid buffer and
// re-emitted on a valid/ready stream grouped into bursts of BURST_LEN beats.
// If the FIFO runs dry with a single word parked in the buffer for TIMEOUT
// consecutive cycles, that word is emitted as the closing beat of a partial
// burst.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst_n          in   synchronous active-low reset
//   fifo_empty     in   FIFO empty flag
//   fifo_dout      in   FIFO registered read data [DATA_WIDTH]
//   fifo_rd_en     out  FIFO read strobe (combinational from registered state)
//   m_valid        out  stream beat valid (registered)
//   m_ready        in   stream sink ready
//   m_data         out  stream beat data [DATA_WIDTH] (registered)
//   m_last         out  final beat of the burst (registered)
//   burst_done     out  pulse the cycle after a handshake with m_last=1
//   timeout_flush  out  pulse the cycle after a handshake of a timeout-closed beat
// -----------------------------------------------------------------------------
module fifo_burst_drain #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  burst_done,
    output logic                  timeout_flush
);

    localparam int              BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]   LAST_IDX  = BW'(BURST_LEN - 1);
    localparam logic [BW-1:0]   BEAT_ZERO = BW'(0);
    localparam logic [BW-1:0]   BEAT_ONE  = BW'(1);
    localparam logic [15:0]     TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // The head closes a burst either by position or because the timeout
    // forced it; both give m_last=1.
    function automatic logic head_is_last(input logic [BW-1:0] idx,
                                          input logic          flush);
        return (idx == LAST_IDX) || flush;
    endfunction

    // A head is presentable when it closes the burst, or when a successor is
    // already buffered (so it is known not to be the last of a partial burst).
    function automatic logic head_eligible(input logic [1:0]    occ,
                                           input logic [BW-1:0] idx,
                                           input logic          flush);
        return (occ != 2'd0) && (head_is_last(idx, flush) || (occ >= 2'd2));
    endfunction

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] buf_q [3];
    logic [DATA_WIDTH-1:0] buf_d [3];
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, inflight_d;
    logic [BW-1:0]         beat_idx_q, beat_idx_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
    logic                  flush_q, flush_d;
    logic                  m_valid_q, m_valid_d;
    logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic                  m_last_q, m_last_d;
    logic                  burst_done_q, burst_done_d;
    logic                  timeout_flush_q, timeout_flush_d;

    logic [2:0]            pending_s;
    logic                  rd_en_s;
    logic                  hs_s;
    logic                  starve_s;
    logic                  tmo_fire_s;
    logic                  head_last_s;

    // Read issue: words in the buffer plus the one in flight must leave room.
    always_comb begin
        pending_s = {1'b0, occ_q} + {2'b00, inflight_q};
        if (rst_n && !fifo_empty && (pending_s < 3'd3)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
        inflight_d = rd_en_s;
    end

    // Skid buffer: pop at the head on handshake, then append the returning word.
    always_comb begin
        hs_s  = m_valid_q && m_ready;
        buf_d = buf_q;
        occ_d = occ_q;
        if (hs_s) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = buf_q[2];
            buf_d[2] = buf_q[2];
            occ_d    = occ_q - 2'd1;
        end else begin
            occ_d    = occ_q;
        end
        // occ_d here is the post-pop occupancy, i.e. the tail slot. The issue
        // rule guarantees it is at most 2 whenever a word is in flight.
        if (inflight_q) begin
            case (occ_d)
                2'd0:    buf_d[0] = fifo_dout;
                2'd1:    buf_d[1] = fifo_dout;
                2'd2:    buf_d[2] = fifo_dout;
                default: buf_d[2] = buf_q[2];
            endcase
            occ_d = occ_d + 2'd1;
        end else begin
            occ_d = occ_d;
        end
    end

    // Idle timeout: count cycles where a lone word waits and nothing can arrive.
    always_comb begin
        starve_s   = (occ_q == 2'd1) && !inflight_q && fifo_empty && !flush_q;
        tmo_fire_s = 1'b0;
        tmo_cnt_d  = 16'd0;
        if (starve_s) begin
            if (tmo_cnt_q == TMO_LAST) begin
                tmo_fire_s = 1'b1;
                tmo_cnt_d  = 16'd0;
            end else begin
                tmo_fire_s = 1'b0;
                tmo_cnt_d  = tmo_cnt_q + 16'd1;
            end
        end else begin
            tmo_fire_s = 1'b0;
            tmo_cnt_d  = 16'd0;
        end

        // The handshake retires the flushed beat. A fire coinciding with a
        // handshake can only be on an already-last head, so nothing is left
        // to flush and the handshake wins.
        if (hs_s) begin
            flush_d = 1'b0;
        end else if (tmo_fire_s) begin
            flush_d = 1'b1;
        end else begin
            flush_d = flush_q;
        end
    end

    // Beat position within the burst; restarts after any closing beat.
    always_comb begin
        beat_idx_d = beat_idx_q;
        if (hs_s) begin
            if (m_last_q) begin
                beat_idx_d = BEAT_ZERO;
            end else begin
                beat_idx_d = beat_idx_q + BEAT_ONE;
            end
        end else begin
            beat_idx_d = beat_idx_q;
        end
    end

    // Stream outputs are computed from next state so they register without
    // adding a cycle; nothing in the next state can disturb a held beat.
    always_comb begin
        head_last_s = head_is_last(beat_idx_d, flush_d);
        m_valid_d   = head_eligible(occ_d, beat_idx_d, flush_d);
        m_last_d    = m_valid_d && head_last_s;
        if (m_valid_d) begin
            m_data_d = buf_d[0];
        end else begin
            m_data_d = DATA_ZERO;
        end
        burst_done_d = hs_s && m_last_q;
        // A head already closing by position is not counted as timeout-closed.
        timeout_flush_d = hs_s && flush_q && (beat_idx_q != LAST_IDX);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= DATA_ZERO;
            end
            occ_q           <= 2'd0;
            inflight_q      <= 1'b0;
            beat_idx_q      <= BEAT_ZERO;
            tmo_cnt_q       <= 16'd0;
            flush_q         <= 1'b0;
            m_valid_q       <= 1'b0;
            m_data_q        <= DATA_ZERO;
            m_last_q        <= 1'b0;
            burst_done_q    <= 1'b0;
            timeout_flush_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= buf_d[i];
            end
            occ_q           <= occ_d;
            inflight_q      <= inflight_d;
            beat_idx_q      <= beat_idx_d;
            tmo_cnt_q       <= tmo_cnt_d;
            flush_q         <= flush_d;
            m_valid_q       <= m_valid_d;
            m_data_q        <= m_data_d;
            m_last_q        <= m_last_d;
            burst_done_q    <= burst_done_d;
            timeout_flush_q <= timeout_flush_d;
        end
    end

    assign fifo_rd_en    = rd_en_s;
    assign m_valid       = m_valid_q;
    assign m_data        = m_data_q;
    assign m_last        = m_last_q;
    assign burst_done    = burst_done_q;
    assign timeout_flush = timeout_flush_q;

endmodule

// File: tb/tb_fifo_burst_drain.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_drain
//
// Directed bench for fifo_burst_drain (DATA_WIDTH=8, BURST_LEN=4, TIMEOUT=16).
// A small FIFO model feeds the DUT; a negedge monitor logs stream beats and
// counts status pulses; directed sequences compare against hand-derived values.
// -----------------------------------------------------------------------------
module tb_fifo_burst_drain;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       fifo_empty;
    logic [7:0] fifo_dout = 8'h00;
    logic       fifo_rd_en;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       burst_done;
    logic       timeout_flush;

    always #5 clk = ~clk;

    fifo_burst_drain #(
        .DATA_WIDTH (8),
        .BURST_LEN  (4),
        .TIMEOUT    (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_empty    (fifo_empty),
        .fifo_dout     (fifo_dout),
        .fifo_rd_en    (fifo_rd_en),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .m_last        (m_last),
        .burst_done    (burst_done),
        .timeout_flush (timeout_flush)
    );

    // FIFO model: registered read data, written by the stimulus.
    logic [7:0] mem [0:63];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;

    assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

    // FIFO model read port
    always @(posedge clk) begin
        if (fifo_rd_en && (wr_ptr != rd_ptr)) begin
            fifo_dout <= mem[rd_ptr[5:0]];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    // Monitor: beats that will handshake on the coming edge, and pulse counts.
    logic [7:0] obs_data [0:63];
    logic       obs_last [0:63];
    int         obs_cyc  [0:63];
    int         obs_n = 0;
    int         cyc = 0;
    int         n_done = 0, n_tflush = 0, n_rd = 0, n_valid = 0, n_rd_empty = 0;

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Negedge sampler
    always @(negedge clk) begin
        if (rst_n && m_valid && m_ready && (obs_n < 64)) begin
            obs_data[obs_n] <= m_data;
            obs_last[obs_n] <= m_last;
            obs_cyc[obs_n]  <= cyc;
            obs_n           <= obs_n + 1;
        end
        if (burst_done)    n_done     <= n_done + 1;
        if (timeout_flush) n_tflush   <= n_tflush + 1;
        if (fifo_rd_en)    n_rd       <= n_rd + 1;
        if (m_valid)       n_valid    <= n_valid + 1;
        if (fifo_rd_en && fifo_empty) n_rd_empty <= n_rd_empty + 1;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_word(input logic [7:0] w);
        mem[wr_ptr[5:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_beats(input string tag, input int target, input int budget);
        int k;
        k = 0;
        while ((obs_n < target) && (k < budget)) begin
            tick(1);
            k++;
        end
        check_val(tag, obs_n, target);
    endtask

    int base, snap_a, snap_b, unstable;

    initial begin
        rst_n   = 1'b0;
        m_ready = 1'b0;

        // ---- Test 1: preloaded 0x10..0x17, reset state, two full bursts ----
        for (int i = 0; i < 8; i++) push_word(8'h10 + 8'(i));
        tick(3);
        check_val("rst_valid", m_valid, 1'b0);
        check_val("rst_last", m_last, 1'b0);
        check_val("rst_data", m_data, 8'h00);
        check_val("rst_done", burst_done, 1'b0);
        check_val("rst_tflush", timeout_flush, 1'b0);
        check_val("rst_rd_en", fifo_rd_en, 1'b0);
        rst_n   = 1'b1;
        m_ready = 1'b1;
        wait_beats("t1_count", 8, 100);
        for (int i = 0; i < 8; i++) begin
            check_val($sformatf("t1_data%0d", i), obs_data[i], 8'h10 + 8'(i));
            check_val($sformatf("t1_last%0d", i), obs_last[i], (i == 3 || i == 7) ? 1'b1 : 1'b0);
        end
        tick(3);
        check_val("t1_done", n_done, 2);
        check_val("t1_tflush", n_tflush, 0);

        // ---- Test 2: two words then idle; second closed by timeout ----
        base   = obs_n;
        snap_a = n_done;
        snap_b = n_tflush;
        push_word(8'hA0);
        push_word(8'hA1);
        wait_beats("t2_first", base + 1, 20);
        check_val("t2_data0", obs_data[base], 8'hA0);
        check_val("t2_last0", obs_last[base], 1'b0);
        wait_beats("t2_second", base + 2, 40);
        check_val("t2_data1", obs_data[base + 1], 8'hA1);
        check_val("t2_last1", obs_last[base + 1], 1'b1);
        check_val("t2_gap", obs_cyc[base + 1] - obs_cyc[base], 17);
        tick(2);
        check_val("t2_done", n_done - snap_a, 1);
        check_val("t2_tflush", n_tflush - snap_b, 1);

        // ---- Test 3: six words with back-pressure, then release ----
        m_ready  = 1'b0;
        base     = obs_n;
        snap_a   = n_rd;
        unstable = 0;
        for (int i = 0; i < 6; i++) push_word(8'h60 + 8'(i));
        tick(4);
        for (int i = 0; i < 16; i++) begin
            if (m_valid !== 1'b1 || m_data !== 8'h60 || m_last !== 1'b0) unstable++;
            tick(1);
        end
        check_val("t3_stable", unstable, 0);
        check_val("t3_hold_valid", m_valid, 1'b1);
        check_val("t3_hold_data", m_data, 8'h60);
        check_val("t3_reads", n_rd - snap_a, 3);
        m_ready = 1'b1;
        wait_beats("t3_count", base + 6, 80);
        for (int i = 0; i < 6; i++) begin
            check_val($sformatf("t3_data%0d", i), obs_data[base + i], 8'h60 + 8'(i));
            check_val($sformatf("t3_last%0d", i), obs_last[base + i], (i == 3 || i == 5) ? 1'b1 : 1'b0);
        end

        // ---- Test 4: empty flag held high through reset and after ----
        force_empty = 1'b1;
        push_word(8'h70);
        push_word(8'h71);
        snap_a = n_rd;
        snap_b = n_valid;
        rst_n  = 1'b0;
        tick(3);
        rst_n  = 1'b1;
        tick(20);
        check_val("t4_no_reads", n_rd - snap_a, 0);
        check_val("t4_no_valid", n_valid - snap_b, 0);
        force_empty = 1'b0;
        base = obs_n;
        wait_beats("t4_count", base + 2, 60);
        check_val("t4_data0", obs_data[base], 8'h70);
        check_val("t4_last1", obs_last[base + 1], 1'b1);

        // ---- Test 5: reset after two beats of a burst ----
        base = obs_n;
        push_word(8'h30);
        push_word(8'h31);
        push_word(8'h32);
        wait_beats("t5_pre", base + 2, 20);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check_val("t5_valid", m_valid, 1'b0);
        check_val("t5_last", m_last, 1'b0);
        check_val("t5_data", m_data, 8'h00);
        check_val("t5_done", burst_done, 1'b0);
        check_val("t5_tflush", timeout_flush, 1'b0);
        check_val("t5_rd_en", fifo_rd_en, 1'b0);
        snap_b = n_valid;
        tick(20);
        check_val("t5_buf_empty", n_valid - snap_b, 0);
        for (int i = 0; i < 4; i++) push_word(8'h40 + 8'(i));
        wait_beats("t5_count", base + 6, 40);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("t5_data%0d", i), obs_data[base + 2 + i], 8'h40 + 8'(i));
            check_val($sformatf("t5_last%0d", i), obs_last[base + 2 + i], (i == 3) ? 1'b1 : 1'b0);
        end

        // ---- Test 6: word arrives while a flushed head is held ----
        m_ready = 1'b0;
        base    = obs_n;
        push_word(8'h55);
        begin
            int k;
            k = 0;
            while ((m_valid !== 1'b1) && (k < 40)) begin
                tick(1);
                k++;
            end
        end
        check_val("t6_flush_valid", m_valid, 1'b1);
        check_val("t6_flush_last", m_last, 1'b1);
        push_word(8'h56);
        tick(4);
        check_val("t6_hold_valid", m_valid, 1'b1);
        check_val("t6_hold_data", m_data, 8'h55);
        check_val("t6_hold_last", m_last, 1'b1);
        snap_a  = n_done;
        snap_b  = n_tflush;
        m_ready = 1'b1;
        wait_beats("t6_first", base + 1, 5);
        check_val("t6_data0", obs_data[base], 8'h55);
        check_val("t6_last0", obs_last[base], 1'b1);
        tick(5);
        check_val("t6_waits", obs_n, base + 1);
        check_val("t6_wait_valid", m_valid, 1'b0);
        check_val("t6_done", n_done - snap_a, 1);
        check_val("t6_tflush", n_tflush - snap_b, 1);
        wait_beats("t6_second", base + 2, 40);
        check_val("t6_data1", obs_data[base + 1], 8'h56);
        check_val("t6_last1", obs_last[base + 1], 1'b1);

        check_val("rd_while_empty", n_rd_empty, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
